// File: rtl/timer_set_datapath.sv
// Timer-set datapath: MM:SS keypad entry, A/B/R time registers, BCD countdown,
// display latch and the registered status bits k7/t for the sequencer.
module timer_set_datapath #(
    parameter int TICK_DIV = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        tick,
    input  logic        key_valid,
    input  logic [3:0]  key_code,
    input  logic        Kc,
    input  logic        La,
    input  logic        Lb,
    input  logic        Ea,
    input  logic        Lr,
    input  logic        Er,
    input  logic [1:0]  s,
    output logic        k7,
    output logic        t,
    output logic [15:0] disp
);

    localparam logic [3:0] KEY_CONFIRM = 4'hE;

    logic [15:0] ent;
    logic [2:0]  cnt;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] r;
    logic [15:0] bus;
    logic        tick_sel;
    logic        dec_en;

    // One-second BCD decrement of MM:SS; zero holds, seconds wrap 00 -> 59.
    function automatic logic [15:0] bcd_dec(input logic [15:0] v);
        logic [3:0] m1, m0, s1, s0;
        {m1, m0, s1, s0} = v;
        if (v == 16'h0000) begin
            return 16'h0000;
        end
        if (s0 != 4'd0) begin
            s0 = s0 - 4'd1;
        end else if (s1 != 4'd0) begin
            s0 = 4'd9;
            s1 = s1 - 4'd1;
        end else begin
            s0 = 4'd9;
            s1 = 4'd5;
            if (m0 != 4'd0) begin
                m0 = m0 - 4'd1;
            end else begin
                m0 = 4'd9;
                m1 = m1 - 4'd1;
            end
        end
        return {m1, m0, s1, s0};
    endfunction

    // Entry is acceptable once four digits are in and the seconds tens digit is 0..5.
    function automatic logic entry_ok(input logic [15:0] e, input logic [2:0] n);
        return (n == 3'd4) && (e[7:4] <= 4'd5);
    endfunction

    generate
        if (TICK_DIV > 0) begin : g_div
            localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
            logic [DIV_W-1:0] div_cnt;
            logic             tick_unused;

            assign tick_unused = tick;
            assign tick_sel    = (div_cnt == DIV_W'(TICK_DIV - 1));

            // Free-running divider: strobe on every TICK_DIV-th cycle after reset release.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    div_cnt <= '0;
                end else if (tick_sel) begin
                    div_cnt <= '0;
                end else begin
                    div_cnt <= div_cnt + 1'b1;
                end
            end
        end else begin : g_ext
            assign tick_sel = tick;
        end
    endgenerate

    // Shared bus feeding every load: ENT, B, A or zero.
    always_comb begin
        bus = 16'h0000;
        unique case (s)
            2'b00: bus = ent;
            2'b01: bus = b;
            2'b10: bus = a;
            2'b11: bus = 16'h0000;
        endcase
    end

    // A load takes priority over counting, so a tick in a load cycle is lost.
    assign dec_en = Ea && tick_sel && !La && (a != 16'h0000);

    // Keypad entry shift register, digit count and confirm status; Kc beats any key.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ent <= 16'h0000;
            cnt <= 3'd0;
            k7  <= 1'b0;
        end else if (Kc) begin
            ent <= 16'h0000;
            cnt <= 3'd0;
            k7  <= 1'b0;
        end else if (key_valid) begin
            if ((key_code <= 4'd9) && (cnt != 3'd4)) begin
                ent <= {ent[11:0], key_code};
                cnt <= cnt + 3'd1;
            end else if ((key_code == KEY_CONFIRM) && entry_ok(ent, cnt)) begin
                k7 <= 1'b1;
            end
        end
    end

    // Countdown register A: bus load or one BCD decrement per qualifying tick.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a <= 16'h0000;
        end else if (La) begin
            a <= bus;
        end else if (dec_en) begin
            a <= bcd_dec(a);
        end
    end

    // Expiry flag: set only when counting reaches zero; La/Kc clear and win ties.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            t <= 1'b0;
        end else if (La || Kc) begin
            t <= 1'b0;
        end else if (dec_en && (a == 16'h0001)) begin
            t <= 1'b1;
        end
    end

    // B and R bus loads plus the display latch, which copies R as it was before the edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            b    <= 16'h0000;
            r    <= 16'h0000;
            disp <= 16'h0000;
        end else begin
            if (Lb) begin
                b <= bus;
            end
            if (Lr) begin
                r <= bus;
            end
            if (Er) begin
                disp <= r;
            end
        end
    end

endmodule

// File: tb/tb_timer_set_datapath.sv
// Bench for timer_set_datapath: directed scenarios plus randomized control words
// checked against a seconds/decimal-level reference model.
module tb_timer_set_datapath;

    logic        clk = 1'b0;
    logic        rst_n, tick, key_valid, Kc, La, Lb, Ea, Lr, Er;
    logic [3:0]  key_code;
    logic [1:0]  s;
    logic        k7, t, k7_d, t_d;
    logic [15:0] disp, disp_d;

    int checks = 0;
    int errors = 0;

    // Reference model state: ENT as a decimal number, A as minutes and seconds.
    int          m_ent, m_cnt, m_min, m_sec;
    logic        m_k7, m_t;
    logic [15:0] m_b, m_r, m_disp;

    timer_set_datapath #(.TICK_DIV(0)) dut (
        .clk(clk), .rst_n(rst_n), .tick(tick), .key_valid(key_valid), .key_code(key_code),
        .Kc(Kc), .La(La), .Lb(Lb), .Ea(Ea), .Lr(Lr), .Er(Er), .s(s),
        .k7(k7), .t(t), .disp(disp)
    );

    timer_set_datapath #(.TICK_DIV(4)) dut_div (
        .clk(clk), .rst_n(rst_n), .tick(tick), .key_valid(key_valid), .key_code(key_code),
        .Kc(Kc), .La(La), .Lb(Lb), .Ea(Ea), .Lr(Lr), .Er(Er), .s(s),
        .k7(k7_d), .t(t_d), .disp(disp_d)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] to_bcd4(input int v);
        return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    function automatic int from_bcd2(input logic [7:0] x);
        return int'(x[7:4]) * 10 + int'(x[3:0]);
    endfunction

    task automatic model_step();
        logic [15:0] bus;
        logic [15:0] a_now;
        if (!rst_n) begin
            m_ent = 0; m_cnt = 0; m_k7 = 1'b0; m_t = 1'b0;
            m_min = 0; m_sec = 0; m_b = '0; m_r = '0; m_disp = '0;
            return;
        end
        a_now = to_bcd4(m_min * 100 + m_sec);
        case (s)
            2'b00:   bus = to_bcd4(m_ent);
            2'b01:   bus = m_b;
            2'b10:   bus = a_now;
            default: bus = 16'h0000;
        endcase
        if (Er) m_disp = m_r;
        if (Lr) m_r = bus;
        if (Lb) m_b = bus;
        if (La) begin
            m_min = from_bcd2(bus[15:8]);
            m_sec = from_bcd2(bus[7:0]);
        end else if (Ea && tick && (m_min * 100 + m_sec) != 0) begin
            if (m_sec > 0) m_sec = m_sec - 1;
            else begin m_min = m_min - 1; m_sec = 59; end
            if (m_min == 0 && m_sec == 0 && !Kc) m_t = 1'b1;
        end
        if (La || Kc) m_t = 1'b0;
        if (Kc) begin
            m_ent = 0; m_cnt = 0; m_k7 = 1'b0;
        end else if (key_valid) begin
            if (key_code <= 4'd9 && m_cnt < 4) begin
                m_ent = m_ent * 10 + int'(key_code);
                m_cnt = m_cnt + 1;
            end else if (key_code == 4'hE && m_cnt == 4 && ((m_ent / 10) % 10) <= 5) begin
                m_k7 = 1'b1;
            end
        end
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rst_n = 1'b1; tick = 1'b0; key_valid = 1'b0; key_code = 4'h0;
        Kc = 1'b0; La = 1'b0; Lb = 1'b0; Ea = 1'b0; Lr = 1'b0; Er = 1'b0; s = 2'b00;
    endtask

    task automatic press(input logic [3:0] code);
        key_valid = 1'b1; key_code = code;
        cycle();
        key_valid = 1'b0; key_code = 4'h0;
    endtask

    task automatic clear_entry();
        Kc = 1'b1; cycle(); Kc = 1'b0;
    endtask

    task automatic load(input logic [1:0] sel, input logic la, input logic lb);
        s = sel; La = la; Lb = lb;
        cycle();
        La = 1'b0; Lb = 1'b0; s = 2'b00;
    endtask

    // Copy a bus source into R, then R into disp.
    task automatic read_bus(input logic [1:0] sel);
        s = sel; Lr = 1'b1; cycle();
        Lr = 1'b0; s = 2'b00; Er = 1'b1; cycle();
        Er = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        rst_n = 1'b0; cycle(); cycle(); rst_n = 1'b1;
        checks++; if (k7 !== 1'b0) begin errors++; $display("FAIL reset_k7 got %b want 0", k7); end
        checks++; if (t !== 1'b0) begin errors++; $display("FAIL reset_t got %b want 0", t); end
        checks++; if (disp !== 16'h0000) begin errors++; $display("FAIL reset_disp got %h want 0000", disp); end
    endtask

    task automatic test_entry();
        idle(); clear_entry();
        press(4'd1); press(4'd2); press(4'd3); press(4'd4); press(4'hE);
        checks++; if (k7 !== 1'b1) begin errors++; $display("FAIL entry_k7 got %b want 1", k7); end
        read_bus(2'b00);
        checks++; if (disp !== 16'h1234) begin errors++; $display("FAIL entry_ent got %h want 1234", disp); end
        load(2'b00, 1'b1, 1'b0);
        read_bus(2'b10);
        checks++; if (disp !== 16'h1234) begin errors++; $display("FAIL entry_load_a got %h want 1234", disp); end
    endtask

    task automatic test_reject();
        idle(); clear_entry();
        press(4'd0); press(4'd9); press(4'd7); press(4'd0); press(4'hE);
        checks++; if (k7 !== 1'b0) begin errors++; $display("FAIL reject_s1_k7 got %b want 0", k7); end
        clear_entry();
        press(4'd0); press(4'd1); press(4'd0); press(4'hE);
        checks++; if (k7 !== 1'b0) begin errors++; $display("FAIL reject_short_k7 got %b want 0", k7); end
        press(4'd5); press(4'd7);
        read_bus(2'b00);
        checks++; if (disp !== 16'h0105) begin errors++; $display("FAIL reject_fifth got %h want 0105", disp); end
    endtask

    task automatic test_countdown();
        int tot;
        idle(); clear_entry();
        press(4'd0); press(4'd1); press(4'd0); press(4'd0);
        load(2'b00, 1'b1, 1'b0);
        Ea = 1'b1;
        for (int i = 1; i <= 63; i++) begin
            tick = 1'b1; cycle(); tick = 1'b0;
            checks++;
            if (t !== (i >= 60)) begin errors++; $display("FAIL cd_t tick %0d got %b want %b", i, t, (i >= 60)); end
            read_bus(2'b10);
            tot = (60 - i > 0) ? 60 - i : 0;
            checks++;
            if (disp !== to_bcd4((tot / 60) * 100 + tot % 60))
                begin errors++; $display("FAIL cd_a tick %0d got %h want %h", i, disp, to_bcd4((tot / 60) * 100 + tot % 60)); end
        end
        Ea = 1'b0;
    endtask

    task automatic test_same_cycle();
        idle(); clear_entry();
        press(4'd0); press(4'd0); press(4'd3); press(4'd0);
        load(2'b00, 1'b0, 1'b1);
        s = 2'b01; La = 1'b1; tick = 1'b1; Ea = 1'b1; cycle();
        checks++; if (t !== 1'b0) begin errors++; $display("FAIL same_t got %b want 0", t); end
        s = 2'b01; La = 1'b1; tick = 1'b1; Ea = 1'b1; cycle();
        idle();
        read_bus(2'b10);
        checks++; if (disp !== 16'h0030) begin errors++; $display("FAIL same_a got %h want 0030", disp); end
        clear_entry();
        press(4'd1); press(4'd2);
        Kc = 1'b1; key_valid = 1'b1; key_code = 4'd5; cycle(); idle();
        read_bus(2'b00);
        checks++; if (disp !== 16'h0000) begin errors++; $display("FAIL kc_key_ent got %h want 0000", disp); end
        press(4'd1); press(4'd2); press(4'd3); press(4'hE);
        checks++; if (k7 !== 1'b0) begin errors++; $display("FAIL kc_key_cnt got %b want 0", k7); end
    endtask

    task automatic test_disp();
        idle(); clear_entry();
        press(4'd4); press(4'd3); press(4'd2); press(4'd1);
        load(2'b00, 1'b1, 1'b0);
        read_bus(2'b10);
        checks++; if (disp !== 16'h4321) begin errors++; $display("FAIL disp_a got %h want 4321", disp); end
        s = 2'b11; Lr = 1'b1; Er = 1'b1; cycle(); idle();
        checks++; if (disp !== 16'h4321) begin errors++; $display("FAIL disp_old_r got %h want 4321", disp); end
        cycle();
        checks++; if (disp !== 16'h4321) begin errors++; $display("FAIL disp_hold got %h want 4321", disp); end
        Er = 1'b1; cycle(); Er = 1'b0;
        checks++; if (disp !== 16'h0000) begin errors++; $display("FAIL disp_zero got %h want 0000", disp); end
    endtask

    task automatic test_reset_mid();
        idle(); clear_entry();
        press(4'd0); press(4'd0); press(4'd4); press(4'd5);
        load(2'b00, 1'b1, 1'b1);
        press(4'hE);
        Ea = 1'b1; tick = 1'b1; cycle(); cycle(); cycle(); idle();
        read_bus(2'b10);
        checks++; if (disp !== 16'h0042) begin errors++; $display("FAIL mid_pre got %h want 0042", disp); end
        rst_n = 1'b0; Ea = 1'b1; tick = 1'b1; cycle(); idle();
        checks++; if (k7 !== 1'b0 || t !== 1'b0) begin errors++; $display("FAIL mid_status got k7=%b t=%b want 0 0", k7, t); end
        checks++; if (disp !== 16'h0000) begin errors++; $display("FAIL mid_disp got %h want 0000", disp); end
        Er = 1'b1; cycle(); Er = 1'b0;
        checks++; if (disp !== 16'h0000) begin errors++; $display("FAIL mid_r got %h want 0000", disp); end
        for (int k = 0; k < 3; k++) begin
            read_bus(2'(k));
            checks++; if (disp !== 16'h0000) begin errors++; $display("FAIL mid_reg%0d got %h want 0000", k, disp); end
        end
    endtask

    task automatic test_tick_div();
        idle(); clear_entry();
        press(4'd0); press(4'd0); press(4'd4); press(4'd2);
        load(2'b00, 1'b1, 1'b0);
        Ea = 1'b1;
        for (int i = 0; i < 40; i++) cycle();
        Ea = 1'b0;
        read_bus(2'b10);
        checks++; if (disp !== 16'h0042) begin errors++; $display("FAIL div_ext got %h want 0042", disp); end
        checks++; if (disp_d !== 16'h0032) begin errors++; $display("FAIL div_int got %h want 0032", disp_d); end
    endtask

    task automatic test_random();
        idle();
        for (int i = 0; i < 600; i++) begin
            rst_n     = ($urandom % 151) != 0;
            key_valid = ($urandom % 3) == 0;
            key_code  = (($urandom % 4) == 0) ? 4'hE : 4'($urandom % 16);
            Kc        = ($urandom % 12) == 0;
            La        = ($urandom % 9) == 0;
            Lb        = ($urandom % 6) == 0;
            Lr        = ($urandom % 4) == 0;
            Er        = ($urandom % 3) == 0;
            Ea        = ($urandom % 4) != 0;
            tick      = ($urandom % 2) == 0;
            s         = 2'($urandom % 4);
            cycle();
            checks++; if (k7 !== m_k7) begin errors++; $display("FAIL rnd_k7 cyc %0d got %b want %b", i, k7, m_k7); end
            checks++; if (t !== m_t) begin errors++; $display("FAIL rnd_t cyc %0d got %b want %b", i, t, m_t); end
            checks++; if (disp !== m_disp) begin errors++; $display("FAIL rnd_disp cyc %0d got %h want %h", i, disp, m_disp); end
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_entry();
        test_reject();
        test_countdown();
        test_same_cycle();
        test_disp();
        test_reset_mid();
        test_tick_div();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
